// File: rtl/frame_gatherer.sv
// frame_gatherer: packs a valid/ready word stream into one frame of DEPTH
// signed entries, then presents it (entries, word count, running sum) until
// the consumer takes it. One frame buffer, so input stalls while a frame is held.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   FILL  | accepting words into out_a[idx], accumulating out_sum
//   HOLD  | frame complete, out_valid=1, outputs frozen until out_ready
module frame_gatherer #(
    parameter int DEPTH = 10,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a [DEPTH],
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_sum
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             frame_done;
    logic             take;

    assign accept     = in_valid && in_ready;
    assign frame_done = accept && ((idx == IDX_W'(DEPTH - 1)) || in_last);
    // take and accept are mutually exclusive: take needs HOLD, accept needs FILL
    assign take       = out_valid && out_ready;

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state: complete on the last accepted word, release on output handshake
    always_comb begin
        state_nxt = state;
        case (state)
            FILL: if (frame_done) state_nxt = HOLD;
            HOLD: if (take)       state_nxt = FILL;
            default:              state_nxt = FILL;
        endcase
    end

    // outputs decoded from state; in_ready drops immediately under reset
    always_comb begin
        in_ready = (state == FILL) && !rst;
    end

    // frame buffer, index, count and sum; cleared on release so unused entries read zero
    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            out_valid <= 1'b0;
            out_b     <= '0;
            out_sum   <= '0;
            for (int i = 0; i < DEPTH; i++) out_a[i] <= '0;
        end else if (take) begin
            out_valid <= 1'b0;
            out_b     <= '0;
            out_sum   <= '0;
            for (int i = 0; i < DEPTH; i++) out_a[i] <= '0;
        end else if (accept) begin
            out_a[idx] <= in_data;
            out_sum    <= out_sum + in_data;
            if (frame_done) begin
                out_valid <= 1'b1;
                out_b     <= WIDTH'(idx) + WIDTH'(1);
                idx       <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_frame_gatherer.sv
// Directed bench for frame_gatherer (DEPTH=10, WIDTH=32) with hand-computed expectations.
module tb_frame_gatherer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a [10];
    logic [31:0] out_b;
    logic [31:0] out_sum;

    int n_cmp = 0;
    int n_err = 0;

    frame_gatherer #(.DEPTH(10), .WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_sum   (out_sum)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    task automatic release_frame();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("rel_valid", {31'b0, out_valid}, 32'd0);
        chk("rel_ready", {31'b0, in_ready}, 32'd1);
        chk("rel_b", out_b, 32'd0);
        chk("rel_sum", out_sum, 32'd0);
        for (int i = 0; i < 10; i++) chk($sformatf("rel_a%0d", i), out_a[i], 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        #1;
        chk("rst_in_ready_low", {31'b0, in_ready}, 32'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_b", out_b, 32'd0);
        chk("rst_sum", out_sum, 32'd0);
        chk("rst_a0", out_a[0], 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // full frame 1..10, no in_last
        for (int i = 1; i <= 9; i++) send(32'(i), 1'b0);
        chk("full_not_yet", {31'b0, out_valid}, 32'd0);
        chk("full_ready_9", {31'b0, in_ready}, 32'd1);
        send(32'd10, 1'b0);
        chk("full_valid", {31'b0, out_valid}, 32'd1);
        chk("full_b", out_b, 32'd10);
        chk("full_sum", out_sum, 32'd55);
        chk("full_in_ready", {31'b0, in_ready}, 32'd0);
        for (int i = 0; i < 10; i++) chk($sformatf("full_a%0d", i), out_a[i], 32'(i + 1));
        release_frame();

        // short frame 7, -2, 5
        send(32'd7, 1'b0);
        send(32'hFFFF_FFFE, 1'b0);
        send(32'd5, 1'b1);
        chk("short_valid", {31'b0, out_valid}, 32'd1);
        chk("short_b", out_b, 32'd3);
        chk("short_sum", out_sum, 32'd10);
        chk("short_a0", out_a[0], 32'd7);
        chk("short_a1", out_a[1], 32'hFFFF_FFFE);
        chk("short_a2", out_a[2], 32'd5);
        for (int i = 3; i < 10; i++) chk($sformatf("short_a%0d", i), out_a[i], 32'd0);
        release_frame();

        // backpressure: 1,2,3 held for 5 cycles while upstream keeps offering 99
        send(32'd1, 1'b0);
        send(32'd2, 1'b0);
        send(32'd3, 1'b1);
        in_valid = 1'b1;
        in_data  = 32'd99;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("bp_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            chk("bp_b", out_b, 32'd3);
            chk("bp_sum", out_sum, 32'd6);
            chk("bp_a0", out_a[0], 32'd1);
            chk("bp_a2", out_a[2], 32'd3);
            chk("bp_a3", out_a[3], 32'd0);
        end
        in_valid = 1'b0;
        in_data  = '0;
        release_frame();
        send(32'd4, 1'b0);
        send(32'd6, 1'b1);
        chk("b2b_valid", {31'b0, out_valid}, 32'd1);
        chk("b2b_b", out_b, 32'd2);
        chk("b2b_sum", out_sum, 32'd10);
        chk("b2b_a0", out_a[0], 32'd4);
        chk("b2b_a1", out_a[1], 32'd6);
        release_frame();

        // sum wrap
        send(32'h7FFF_FFFF, 1'b0);
        send(32'h0000_0001, 1'b1);
        chk("wrap_sum", out_sum, 32'h8000_0000);
        chk("wrap_b", out_b, 32'd2);
        release_frame();

        // reset during FILL discards partial frame
        for (int i = 1; i <= 4; i++) send(32'(i), 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rstf_valid", {31'b0, out_valid}, 32'd0);
        chk("rstf_sum", out_sum, 32'd0);
        chk("rstf_a0", out_a[0], 32'd0);
        send(32'd9, 1'b1);
        chk("rstf_valid2", {31'b0, out_valid}, 32'd1);
        chk("rstf_b", out_b, 32'd1);
        chk("rstf_sum2", out_sum, 32'd9);
        chk("rstf_a0b", out_a[0], 32'd9);
        for (int i = 1; i < 10; i++) chk($sformatf("rstf_a%0d", i), out_a[i], 32'd0);

        // reset during HOLD drops the presented frame
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rsth_valid", {31'b0, out_valid}, 32'd0);
        chk("rsth_b", out_b, 32'd0);
        chk("rsth_in_ready", {31'b0, in_ready}, 32'd1);

        // in_last on word 10: exactly one frame
        for (int i = 1; i <= 9; i++) send(32'(i), 1'b0);
        send(32'd10, 1'b1);
        chk("last10_valid", {31'b0, out_valid}, 32'd1);
        chk("last10_b", out_b, 32'd10);
        chk("last10_sum", out_sum, 32'd55);
        release_frame();
        for (int c = 0; c < 3; c++) begin
            step();
            chk("last10_no_2nd", {31'b0, out_valid}, 32'd0);
            chk("last10_in_ready", {31'b0, in_ready}, 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
